alu_arb: RTL and testbench
==========================

Name: alu_arb

Overview:
- Sequencer/arbiter that shares one combinational 4-bit `alu` instance between two requesters (port 0, port 1).
- Arbitrates pending requests round-robin and registers the granted operands onto the ALU input bus.
- Waits one settle cycle, captures R and flags, then returns them to the winner with a one-cycle done pulse.
- Sits between the datapath control logic and the `alu` instance; it owns all ALU inputs.

Parameters:
- WIDTH, 4, operand/result width; must match `alu` (4).
- PRIO_INIT, 0, requester holding priority after reset (0 or 1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req0, req1  input  1 each  request level; held until matching done seen.
- a0, b0, a1, b1  input  WIDTH each  operands per requester.
- op0, op1  input  2 each  ALUOp per requester.
- l0, l1  input  1 each  arithmetic(0)/logic(1) select per requester.
- gnt0, gnt1  output  1 each  high for the EXEC cycle of that requester's transaction.
- done0, done1  output  1 each  one-cycle pulse, result valid.
- res  output  WIDTH  captured R.
- res_zero, res_carry, res_sign  output  1 each  captured flags.
- busy  output  1  high in EXEC and DONE.
- alu_a, alu_b  output  WIDTH each  to ALU A, B.
- alu_op  output  2  to ALU ALUOp.
- alu_l  output  1  to ALU l.
- alu_r  input  WIDTH  from ALU R.
- alu_zero, alu_carry, alu_sign  input  1 each  from ALU flags.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, prio=PRIO_INIT.
  - alu_a=alu_b=0, alu_op=0, alu_l=0.
  - res=0, all res_* flags=0.
  - gnt*/done*/busy=0.
- FSM states: IDLE, EXEC, DONE. All outputs registered or decoded from state only; no req-to-output combinational path.
- IDLE, no req: stay in IDLE; ALU input registers hold their last values.
- IDLE, exactly one req high: latch that requester's a/b/op/l into alu_* registers, latch owner id, go to EXEC.
- IDLE, both req high: winner = prio. Latch the winner's operands, go to EXEC, set prio = the loser, so the loser wins next.
- IDLE, single requester: set prio = the other requester, so that requester wins the next tie.
- EXEC (1 cycle):
  - gnt[owner]=1, busy=1; ALU settles.
  - At the clock edge: res<=alu_r, res_zero<=alu_zero, res_sign<=alu_sign, res_carry<=alu_carry.
  - X/Z sanitizing: a flag captures 1 only if its input is exactly 1, else 0. This applies because the ALU drives X on carry/sign in some modes.
  - Then go to DONE.
- DONE (1 cycle): done[owner]=1, busy=1; next state IDLE.
- res/res_* hold their value until the next EXEC capture.
- Latency: req sampled in IDLE cycle N -> gnt in N+1 -> done in N+2. Maximum throughput is one op per 3 cycles.
- Request rule: requester drops req at the edge after it sees done. req is ignored outside IDLE.
- Operands are latched at grant, so a/b/op/l changes after grant do not affect the transaction.
- A requester whose req is still high in IDLE after its done starts a new transaction. This is legal back-to-back, subject to round-robin.
- Starvation bound: a continuously asserted req is served within 2 transactions.
- Reset mid-EXEC or mid-DONE: transaction aborted, no done pulse, all outputs to reset values immediately.
- Arithmetic: the controller performs no arithmetic. Widths pass through unchanged; no sign extension.

Decomposition:
- Shared package `alu_pkg`:
  - ALUOp encodings: OP_NEG_A=2'b00, OP_NEG_B=2'b01, OP_ADD=2'b10, OP_SUB=2'b11.
  - Mode constants: MODE_ARITH=0, MODE_LOGIC=1.
  - FSM state encodings: IDLE=2'b00, EXEC=2'b01, DONE=2'b10.
- One natural sub-module: `rr_arb2`, a 2-way round-robin pick with prio register and update, about 30 lines.
- The `alu` itself is instantiated alongside alu_arb at the top level, not inside it.

Test Plan:
- Reset then idle, no req: all outputs 0; alu_* stay 0 for 10 cycles.
- req0 with a0=3, b0=2, op0=2'b10, l0=0 -> gnt0 next cycle, then done0 with res=5, zero=0, carry=0.
- req1 with a1=3, b1=2, op1=2'b11, l1=0 (3+~2+1=17) -> done1 with res=1, carry=1, zero=0.
- Zero flag: req0 with a0=5, b0=5, op0=2'b11 -> done0 with res=0, zero=1, carry=1.
- Simultaneous req0 and req1 held for 4 transactions with PRIO_INIT=0 -> grant order 0,1,0,1. Each done follows its gnt by 1 cycle; the two never overlap.
- Reset asserted during EXEC -> done never pulses; outputs 0 at once. After release, a pending req1 is served with prio=PRIO_INIT.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU encodings, mode constants and controller state encodings.
package alu_pkg;

    localparam int unsigned ALU_W = 4;
    localparam int unsigned OP_W  = 2;
    localparam int unsigned ST_W  = 2;

    // ALUOp encodings
    localparam logic [OP_W-1:0] OP_NEG_A = 2'b00;
    localparam logic [OP_W-1:0] OP_NEG_B = 2'b01;
    localparam logic [OP_W-1:0] OP_ADD   = 2'b10;
    localparam logic [OP_W-1:0] OP_SUB   = 2'b11;

    // ALU mode select
    localparam logic MODE_ARITH = 1'b0;
    localparam logic MODE_LOGIC = 1'b1;

    // Controller FSM states
    localparam logic [ST_W-1:0] IDLE = 2'b00;
    localparam logic [ST_W-1:0] EXEC = 2'b01;
    localparam logic [ST_W-1:0] DONE = 2'b10;

    // Collapse an ALU flag to a clean bit: only a definite 1 counts as set,
    // because the ALU leaves carry/sign undriven in logic mode.
    function automatic logic flag_clean(input logic f);
        if (f == 1'b1) begin
            return 1'b1;
        end
        return 1'b0;
    endfunction

endpackage

// File: rtl/alu_arb_rr_arb2.sv
// Two-way round-robin pick; the winner hands priority to the other side.
module rr_arb2
    import alu_pkg::*;
#(
    parameter int unsigned PRIO_INIT = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic take,
    output logic win_c,
    output logic any_c
);

    logic prio_q;

    // Winner selection: a lone requester wins, a tie goes to prio.
    always_comb begin
        any_c = req0 | req1;
        win_c = prio_q;
        if (req0 && !req1) begin
            win_c = 1'b0;
        end else if (req1 && !req0) begin
            win_c = 1'b1;
        end
    end

    // After every accepted pick the other requester holds priority.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio_q <= 1'(PRIO_INIT);
        end else if (take) begin
            prio_q <= ~win_c;
        end
    end

endmodule

// File: rtl/alu_arb.sv
// Shares one combinational ALU between two requesters: arbitrate, drive
// registered operands, capture result one cycle later, pulse done.
module alu_arb
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned PRIO_INIT = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [1:0]       op0,
    input  logic [1:0]       op1,
    input  logic             l0,
    input  logic             l1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] res,
    output logic             res_zero,
    output logic             res_carry,
    output logic             res_sign,
    output logic             busy,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_op,
    output logic             alu_l,
    input  logic [WIDTH-1:0] alu_r,
    input  logic             alu_zero,
    input  logic             alu_carry,
    input  logic             alu_sign
);

    logic [ST_W-1:0]  state_q;
    logic [ST_W-1:0]  state_d;
    logic             owner_q;
    logic             owner_d;
    logic             load;
    logic             capture;
    logic             win_c;
    logic             any_c;
    logic             gnt0_d;
    logic             gnt1_d;
    logic             done0_d;
    logic             done1_d;
    logic             busy_d;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [1:0]       sel_op;
    logic             sel_l;

    // Round-robin pick; priority advances only when a grant is taken.
    rr_arb2 #(
        .PRIO_INIT (PRIO_INIT)
    ) u_rr (
        .clk   (clk),
        .reset (reset),
        .req0  (req0),
        .req1  (req1),
        .take  (load),
        .win_c (win_c),
        .any_c (any_c)
    );

    // Operand mux in front of the ALU input registers.
    always_comb begin
        sel_a  = win_c ? a1  : a0;
        sel_b  = win_c ? b1  : b0;
        sel_op = win_c ? op1 : op0;
        sel_l  = win_c ? l1  : l0;
    end

    // Next-state and next-output decode.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_c) begin
                    state_d = EXEC;
                    load    = 1'b1;
                end
            end
            EXEC: begin
                state_d = DONE;
                capture = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        owner_d = load ? win_c : owner_q;
        gnt0_d  = (state_d == EXEC) && !owner_d;
        gnt1_d  = (state_d == EXEC) &&  owner_d;
        done0_d = (state_d == DONE) && !owner_d;
        done1_d = (state_d == DONE) &&  owner_d;
        busy_d  = (state_d != IDLE);
    end

    // State, owner and registered handshake outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            done0   <= 1'b0;
            done1   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            gnt0    <= gnt0_d;
            gnt1    <= gnt1_d;
            done0   <= done0_d;
            done1   <= done1_d;
            busy    <= busy_d;
        end
    end

    // ALU input registers: loaded at grant, otherwise hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= 2'b00;
            alu_l  <= 1'b0;
        end else if (load) begin
            alu_a  <= sel_a;
            alu_b  <= sel_b;
            alu_op <= sel_op;
            alu_l  <= sel_l;
        end
    end

    // Result capture at the end of the settle cycle, flags sanitized.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res       <= '0;
            res_zero  <= 1'b0;
            res_carry <= 1'b0;
            res_sign  <= 1'b0;
        end else if (capture) begin
            res       <= alu_r;
            res_zero  <= flag_clean(alu_zero);
            res_carry <= flag_clean(alu_carry);
            res_sign  <= flag_clean(alu_sign);
        end
    end

endmodule

// File: tb/tb_alu_arb.sv
// Self-checking bench for alu_arb with a behavioural ALU and arbitration model.
module tb_alu_arb;

    logic       clk;
    logic       reset;
    logic       req0, req1;
    logic [3:0] a0, b0, a1, b1;
    logic [1:0] op0, op1;
    logic       l0, l1;
    logic       gnt0, gnt1, done0, done1;
    logic [3:0] res;
    logic       res_zero, res_carry, res_sign;
    logic       busy;
    logic [3:0] alu_a, alu_b;
    logic [1:0] alu_op;
    logic       alu_l;
    logic [3:0] alu_r;
    logic       alu_zero, alu_carry, alu_sign;
    logic [4:0] alu_t;

    int total = 0;
    int bad   = 0;
    logic prio_m;

    alu_arb #(.WIDTH(4), .PRIO_INIT(0)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .op0(op0), .op1(op1), .l0(l0), .l1(l1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .res(res), .res_zero(res_zero), .res_carry(res_carry), .res_sign(res_sign),
        .busy(busy),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_l(alu_l),
        .alu_r(alu_r), .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_sign(alu_sign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: {carry, R}
    function automatic logic [4:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                           input logic [1:0] op, input logic l);
        logic [4:0] t;
        if (l) begin
            case (op)
                2'b00:   t = {1'b0, ~a};
                2'b01:   t = {1'b0, ~b};
                2'b10:   t = {1'b0, a & b};
                default: t = {1'b0, a | b};
            endcase
        end else begin
            case (op)
                2'b00:   t = {1'b0, ~a} + 5'd1;
                2'b01:   t = {1'b0, ~b} + 5'd1;
                2'b10:   t = {1'b0, a} + {1'b0, b};
                default: t = {1'b0, a} + {1'b0, ~b} + 5'd1;
            endcase
        end
        return t;
    endfunction

    // Expected captured {sign, carry, zero, R}; undriven logic-mode flags read as 0
    function automatic logic [6:0] exp_of(input logic [3:0] a, input logic [3:0] b,
                                          input logic [1:0] op, input logic l);
        logic [4:0] t;
        t = alu_ref(a, b, op, l);
        return {l ? 1'b0 : t[3], l ? 1'b0 : t[4], (t[3:0] == 4'd0), t[3:0]};
    endfunction

    // ALU sitting on the controller's bus; carry/sign undriven in logic mode
    assign alu_t     = alu_ref(alu_a, alu_b, alu_op, alu_l);
    assign alu_r     = alu_t[3:0];
    assign alu_zero  = (alu_t[3:0] == 4'd0);
    assign alu_carry = alu_l ? 1'bx : alu_t[4];
    assign alu_sign  = alu_l ? 1'bx : alu_t[3];

    function automatic logic pick(input logic r0, input logic r1, input logic p);
        if (r0 && r1) return p;
        return r1;
    endfunction

    task automatic scramble();
        a0 = 4'($urandom); b0 = 4'($urandom); op0 = 2'($urandom); l0 = 1'($urandom);
        a1 = 4'($urandom); b1 = 4'($urandom); op1 = 2'($urandom); l1 = 1'($urandom);
    endtask

    task automatic test_reset();
        reset = 1'b0; req0 = 0; req1 = 0;
        a0 = 4'd9; b0 = 4'd6; a1 = 4'd12; b1 = 4'd1; op0 = 2'b10; op1 = 2'b11; l0 = 0; l1 = 1;
        #12;
        total++;
        if ({gnt1, gnt0, done1, done0, busy, res, res_zero, res_carry, res_sign,
             alu_a, alu_b, alu_op, alu_l} !== 23'd0) begin
            bad++;
            $display("FAIL reset_state: got outputs not all zero (busy=%b res=%h alu_a=%h)", busy, res, alu_a);
        end
        @(negedge clk); reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            total++;
            if ({gnt1, gnt0, done1, done0, busy, res, alu_a, alu_b, alu_op, alu_l} !== 20'd0) begin
                bad++;
                $display("FAIL idle_hold cycle %0d: got busy=%b gnt=%b%b alu_a=%h alu_b=%h want all 0",
                         i, busy, gnt1, gnt0, alu_a, alu_b);
            end
        end
    endtask

    task automatic test_directed();
        logic       port [3];
        logic [3:0] ea [3];
        logic [3:0] eb [3];
        logic [1:0] eop [3];
        logic [3:0] eres [3];
        logic       ez [3];
        logic       ec [3];
        port = '{1'b0, 1'b1, 1'b0};
        ea   = '{4'd3, 4'd3, 4'd5};
        eb   = '{4'd2, 4'd2, 4'd5};
        eop  = '{2'b10, 2'b11, 2'b11};
        eres = '{4'd5, 4'd1, 4'd0};
        ez   = '{1'b0, 1'b0, 1'b1};
        ec   = '{1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            if (port[i]) begin
                a1 = ea[i]; b1 = eb[i]; op1 = eop[i]; l1 = 1'b0; req1 = 1'b1;
            end else begin
                a0 = ea[i]; b0 = eb[i]; op0 = eop[i]; l0 = 1'b0; req0 = 1'b1;
            end
            @(posedge clk); #1;
            total++;
            if ({gnt1, gnt0, busy, done1, done0} !== {port[i], ~port[i], 1'b1, 2'b00}) begin
                bad++;
                $display("FAIL directed%0d_gnt: got gnt=%b%b busy=%b done=%b%b want gnt port %0d busy 1",
                         i, gnt1, gnt0, busy, done1, done0, port[i]);
            end
            a0 = ~a0; b0 = ~b0; a1 = ~a1; b1 = ~b1; op0 = ~op0; op1 = ~op1;
            @(posedge clk); #1;
            total++;
            if ({done1, done0, gnt1, gnt0, busy} !== {port[i], ~port[i], 2'b00, 1'b1} ||
                {res, res_zero, res_carry} !== {eres[i], ez[i], ec[i]}) begin
                bad++;
                $display("FAIL directed%0d_done: got done=%b%b res=%h z=%b c=%b want res=%h z=%b c=%b",
                         i, done1, done0, res, res_zero, res_carry, eres[i], ez[i], ec[i]);
            end
            req0 = 1'b0; req1 = 1'b0;
            @(posedge clk); #1;
            total++;
            if ({busy, done1, done0, res} !== {3'b000, eres[i]}) begin
                bad++;
                $display("FAIL directed%0d_idle: got busy=%b done=%b%b res=%h want 0,00,%h",
                         i, busy, done1, done0, res, eres[i]);
            end
            prio_m = ~port[i];
        end
    endtask

    task automatic test_round_robin();
        logic       w;
        logic [6:0] e;
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        prio_m = 1'b0;
        scramble();
        req0 = 1'b1; req1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            w = pick(1'b1, 1'b1, prio_m);
            e = w ? exp_of(a1, b1, op1, l1) : exp_of(a0, b0, op0, l0);
            @(posedge clk); #1;
            total++;
            if ({gnt1, gnt0, done1, done0, busy} !== {w, ~w, 2'b00, 1'b1} || w !== 1'(k % 2)) begin
                bad++;
                $display("FAIL rr%0d_gnt: got gnt=%b%b done=%b%b want grant to port %0d",
                         k, gnt1, gnt0, done1, done0, k % 2);
            end
            prio_m = ~w;
            scramble();
            @(posedge clk); #1;
            total++;
            if ({done1, done0, gnt1, gnt0} !== {w, ~w, 2'b00} ||
                {res_sign, res_carry, res_zero, res} !== e) begin
                bad++;
                $display("FAIL rr%0d_done: got done=%b%b gnt=%b%b res=%h flags=%b%b%b want port %0d res=%h flags=%b",
                         k, done1, done0, gnt1, gnt0, res, res_sign, res_carry, res_zero, w, e[3:0], e[6:4]);
            end
            @(posedge clk); #1;
            total++;
            if ({gnt1, gnt0, done1, done0, busy} !== 5'd0) begin
                bad++;
                $display("FAIL rr%0d_gap: got gnt=%b%b done=%b%b busy=%b want all 0",
                         k, gnt1, gnt0, done1, done0, busy);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_random();
        logic       w;
        logic [6:0] e;
        logic [3:0] last_a;
        logic [3:0] last_b;
        last_a = alu_a; last_b = alu_b;
        for (int it = 0; it < 40; it++) begin
            if (!req0) req0 = 1'($urandom_range(0, 1));
            if (!req1) req1 = 1'($urandom_range(0, 1));
            scramble();
            if (!req0 && !req1) begin
                @(posedge clk); #1;
                total++;
                if ({busy, gnt1, gnt0} !== 3'b000 || alu_a !== last_a || alu_b !== last_b) begin
                    bad++;
                    $display("FAIL rand%0d_noreq: got busy=%b gnt=%b%b alu_a=%h alu_b=%h want idle, alu %h %h",
                             it, busy, gnt1, gnt0, alu_a, alu_b, last_a, last_b);
                end
                continue;
            end
            w = pick(req0, req1, prio_m);
            e = w ? exp_of(a1, b1, op1, l1) : exp_of(a0, b0, op0, l0);
            last_a = w ? a1 : a0;
            last_b = w ? b1 : b0;
            @(posedge clk); #1;
            total++;
            if ({gnt1, gnt0, busy} !== {w, ~w, 1'b1} || alu_a !== last_a || alu_b !== last_b) begin
                bad++;
                $display("FAIL rand%0d_gnt: got gnt=%b%b alu_a=%h alu_b=%h want port %0d alu %h %h",
                         it, gnt1, gnt0, alu_a, alu_b, w, last_a, last_b);
            end
            prio_m = ~w;
            scramble();
            @(posedge clk); #1;
            total++;
            if ({done1, done0, busy} !== {w, ~w, 1'b1} ||
                {res_sign, res_carry, res_zero, res} !== e) begin
                bad++;
                $display("FAIL rand%0d_done: got done=%b%b res=%h flags=%b%b%b want port %0d res=%h flags=%b",
                         it, done1, done0, res, res_sign, res_carry, res_zero, w, e[3:0], e[6:4]);
            end
            if (w) req1 = 1'b0; else req0 = 1'b0;
            @(posedge clk); #1;
            total++;
            if ({busy, done1, done0} !== 3'b000) begin
                bad++;
                $display("FAIL rand%0d_idle: got busy=%b done=%b%b want 0", it, busy, done1, done0);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_exec();
        logic       w;
        logic [6:0] e;
        scramble();
        req0 = 1'b1; req1 = 1'b1;
        @(posedge clk); #1;
        #2 reset = 1'b0;
        #1;
        total++;
        if ({gnt1, gnt0, done1, done0, busy, res, res_zero, res_carry, res_sign,
             alu_a, alu_b, alu_op, alu_l} !== 23'd0) begin
            bad++;
            $display("FAIL reset_exec_now: got gnt=%b%b busy=%b res=%h alu_a=%h want all 0",
                     gnt1, gnt0, busy, res, alu_a);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total++;
            if ({done1, done0, busy} !== 3'b000) begin
                bad++;
                $display("FAIL reset_exec_nodone%0d: got done=%b%b busy=%b want 0", i, done1, done0, busy);
            end
        end
        @(negedge clk); reset = 1'b1;
        prio_m = 1'b0;
        for (int k = 0; k < 2; k++) begin
            w = pick(req0, req1, prio_m);
            e = w ? exp_of(a1, b1, op1, l1) : exp_of(a0, b0, op0, l0);
            @(posedge clk); #1;
            total++;
            if ({gnt1, gnt0} !== {w, ~w} || w !== 1'(k)) begin
                bad++;
                $display("FAIL post_reset%0d_gnt: got gnt=%b%b want port %0d", k, gnt1, gnt0, k);
            end
            prio_m = ~w;
            @(posedge clk); #1;
            total++;
            if ({done1, done0} !== {w, ~w} || {res_sign, res_carry, res_zero, res} !== e) begin
                bad++;
                $display("FAIL post_reset%0d_done: got done=%b%b res=%h want port %0d res=%h",
                         k, done1, done0, res, w, e[3:0]);
            end
            if (w) req1 = 1'b0; else req0 = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        prio_m = 1'b0;
        test_reset();
        test_directed();
        test_round_robin();
        test_random();
        test_reset_mid_exec();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
